// File: rtl/iob_uart_master.sv
// iob_uart_master: UART command frames in, IOb master transactions out, ACK/NAK/read data back over UART.
module iob_uart_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0]       bit_duration_i,
    input  logic              rxd_i,
    output logic              txd_o,
    output logic              iob_valid_o,
    output logic [ADDR_W-1:0] iob_addr_o,
    output logic [DATA_W-1:0] iob_wdata_o,
    output logic [3:0]        iob_wstrb_o,
    input  logic              iob_ready_i,
    input  logic              iob_rvalid_i,
    input  logic [DATA_W-1:0] iob_rdata_i,
    output logic              busy_o
);
    localparam int NA = ADDR_W / 8;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_t;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, REQ, WAIT_RD, RESP} st_t;
    logic [2:0] rxd_s_q, rxd_s_d;
    rx_t rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_bd_q, rx_bd_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic rx_vld, rx_in;
    logic tx_act_q, tx_act_d, tx_start, tx_done;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_bd_q, tx_bd_d;
    logic [3:0] tx_nb_q, tx_nb_d;
    logic [9:0] tx_sh_q, tx_sh_d;
    st_t st_q, st_d;
    logic wr_q, wr_d;
    logic [2:0] cnt_q, cnt_d, nrsp_q, nrsp_d;
    logic [TW-1:0] to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rsp_q, rsp_d;
    logic [3:0] wstrb_q, wstrb_d;

    assign rxd_s_d = {rxd_s_q[1:0], rxd_i};
    assign rx_in = rxd_s_q[1];
    assign txd_o = tx_sh_q[0];
    assign iob_valid_o = st_q == REQ;
    assign iob_addr_o = addr_q;
    assign iob_wdata_o = wdata_q;
    assign iob_wstrb_o = wstrb_q;
    assign busy_o = st_q != IDLE;
    assign tx_start = st_q == RESP && !tx_act_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d = rx_cnt_q - 16'd1;
        rx_bd_d = rx_bd_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;
        rx_vld = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rxd_s_q[2] && !rx_in) begin
                rx_state_d = RX_START;
                rx_bd_d = bit_duration_i;
                rx_cnt_d = (bit_duration_i >> 1) - 16'd1;
            end
            RX_START: if (rx_cnt_q == 16'd0) begin
                rx_state_d = rx_in ? RX_IDLE : RX_DATA;
                rx_cnt_d = rx_bd_q - 16'd1;
                rx_bit_d = 3'd0;
            end
            RX_DATA: if (rx_cnt_q == 16'd0) begin
                rx_sh_d = {rx_in, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                rx_cnt_d = rx_bd_q - 16'd1;
                rx_state_d = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (rx_cnt_q == 16'd0) begin
                rx_vld = rx_in;
                rx_state_d = rx_in ? RX_IDLE : RX_WAITHI;
            end
            RX_WAITHI: rx_state_d = rx_in ? RX_IDLE : RX_WAITHI;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_act_d = tx_act_q;
        tx_cnt_d = tx_cnt_q;
        tx_bd_d = tx_bd_q;
        tx_nb_d = tx_nb_q;
        tx_sh_d = tx_sh_q;
        tx_done = 1'b0;
        if (tx_start) begin
            tx_act_d = 1'b1;
            tx_bd_d = bit_duration_i;
            tx_cnt_d = bit_duration_i - 16'd1;
            tx_nb_d = 4'd9;
            tx_sh_d = {1'b1, rsp_q[7:0], 1'b0};
        end else if (tx_act_q) begin
            tx_cnt_d = tx_cnt_q - 16'd1;
            if (tx_cnt_q == 16'd0) begin
                tx_done = tx_nb_q == 4'd0;
                tx_act_d = tx_nb_q != 4'd0;
                tx_sh_d = {1'b1, tx_sh_q[9:1]};
                tx_nb_d = tx_nb_q - 4'd1;
                tx_cnt_d = tx_bd_q - 16'd1;
            end
        end
    end

    always_comb begin
        st_d = st_q;
        wr_d = wr_q;
        cnt_d = cnt_q;
        to_d = '0;
        addr_d = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rsp_d = rsp_q;
        nrsp_d = nrsp_q;
        case (st_q)
            IDLE: st_d = rx_vld ? CMD : IDLE;
            CMD: begin
                cnt_d = 3'd0;
                wr_d = rx_sh_q == 8'h57;
                st_d = (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) ? ADDR : RESP;
                rsp_d = DATA_W'(32'h15);
                nrsp_d = 3'd1;
            end
            ADDR, DATA: begin
                to_d = to_q + TW'(1);
                if (rx_vld) begin
                    to_d = '0;
                    cnt_d = cnt_q + 3'd1;
                    if (st_q == ADDR) begin
                        addr_d = ADDR_W'({rx_sh_q, addr_q} >> 8);
                        if (cnt_q == 3'(NA - 1)) begin
                            cnt_d = 3'd0;
                            st_d = wr_q ? DATA : REQ;
                            wstrb_d = 4'h0;
                        end
                    end else begin
                        wdata_d = {rx_sh_q, wdata_q[DATA_W-1:8]};
                        if (cnt_q == 3'd3) begin
                            st_d = REQ;
                            wstrb_d = 4'hF;
                        end
                    end
                end else if (to_q == TW'(TIMEOUT_CYC)) st_d = IDLE;
            end
            REQ: if (iob_ready_i) begin
                wstrb_d = 4'h0;
                st_d = wr_q ? RESP : WAIT_RD;
                rsp_d = DATA_W'(32'h06);
                nrsp_d = 3'd1;
            end
            WAIT_RD: if (iob_rvalid_i) begin
                st_d = RESP;
                rsp_d = iob_rdata_i;
                nrsp_d = 3'd4;
            end
            RESP: if (tx_done) begin
                rsp_d = rsp_q >> 8;
                nrsp_d = nrsp_q - 3'd1;
                st_d = nrsp_q == 3'd1 ? IDLE : RESP;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_s_q <= '1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q <= '0;
            rx_bd_q <= '0;
            rx_bit_q <= '0;
            rx_sh_q <= '0;
            tx_act_q <= 1'b0;
            tx_cnt_q <= '0;
            tx_bd_q <= '0;
            tx_nb_q <= '0;
            tx_sh_q <= '1;
            st_q <= IDLE;
            wr_q <= 1'b0;
            cnt_q <= '0;
            to_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rsp_q <= '0;
            nrsp_q <= '0;
        end else begin
            rxd_s_q <= rxd_s_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bd_q <= rx_bd_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q <= rx_sh_d;
            tx_act_q <= tx_act_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bd_q <= tx_bd_d;
            tx_nb_q <= tx_nb_d;
            tx_sh_q <= tx_sh_d;
            st_q <= st_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
            to_q <= to_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rsp_q <= rsp_d;
            nrsp_q <= nrsp_d;
        end
    end
endmodule

// File: tb/tb_iob_uart_master.sv
// tb_iob_uart_master: directed UART command sequences with request/reply scoreboards and a simple IOb slave.
module tb_iob_uart_master;
    localparam int TO = 300;
    typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] s;} req_t;
    logic clk = 0, rst = 1, rxd = 1, ready = 0, rvalid = 0;
    logic [15:0] bd = 16'd8;
    logic [31:0] rdata = 0, addr, wdata, rd_val = 0, last_wd = 0;
    logic [3:0] wstrb;
    logic txd, valid, busy;
    bit hold_ready = 0;
    int n_chk = 0, n_fail = 0;
    req_t exp_req[$];
    logic [7:0] exp_tx[$];

    iob_uart_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst), .bit_duration_i(bd), .rxd_i(rxd), .txd_o(txd),
        .iob_valid_o(valid), .iob_addr_o(addr), .iob_wdata_o(wdata), .iob_wstrb_o(wstrb),
        .iob_ready_i(ready), .iob_rvalid_i(rvalid), .iob_rdata_i(rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
        @(negedge clk);
        rxd = 1'b0;
        repeat (bd) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bd) @(negedge clk);
        end
        rxd = stop;
        repeat (bd) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic write_cmd(input logic [31:0] a, input logic [31:0] d);
        exp_req.push_back('{a, d, 4'hF});
        exp_tx.push_back(8'h06);
        last_wd = d;
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic read_cmd(input logic [31:0] a, input logic [31:0] rd);
        exp_req.push_back('{a, last_wd, 4'h0});
        rd_val = rd;
        for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while ((busy || exp_tx.size() > 0 || exp_req.size() > 0) && i < 20000) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(busy || exp_tx.size() > 0 || exp_req.size() > 0), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic reset_in_req(input string tag);
        int i = 0;
        hold_ready = 1;
        send_byte(8'h57);
        for (int k = 0; k < 8; k++) send_byte(8'h44);
        while (!valid && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_valid_up"}, 32'(valid), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_txd"}, 32'(txd), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wstrb"}, 32'(wstrb), 32'd0);
        chk({tag, "_addr"}, addr, 32'd0);
        hold_ready = 0;
        last_wd = 0;
        repeat (5) @(negedge clk);
    endtask

    // IOb slave: ready 3 cycles into valid, rdata 2 cycles after handshake
    initial begin : slave
        int vcnt;
        int rvd;
        bit is_rd;
        req_t r;
        vcnt = 0;
        rvd = 0;
        is_rd = 0;
        forever begin
            @(negedge clk);
            rvalid = 1'b0;
            if (rvd > 0) begin
                rvd--;
                if (rvd == 0) begin
                    rvalid = 1'b1;
                    rdata = rd_val;
                end
            end
            if (ready) begin
                ready = 1'b0;
                vcnt = 0;
                chk("valid_drop", 32'(valid), 32'd0);
                chk("wstrb_clear", 32'(wstrb), 32'd0);
                if (is_rd) rvd = 1;
            end else if (valid && !hold_ready) begin
                vcnt++;
                if (vcnt == 3) begin
                    ready = 1'b1;
                    is_rd = wstrb == 4'h0;
                    chk("req_expected", 32'(exp_req.size() > 0), 32'd1);
                    if (exp_req.size() > 0) begin
                        r = exp_req.pop_front();
                        chk("req_addr", addr, r.a);
                        chk("req_wdata", wdata, r.d);
                        chk("req_wstrb", 32'(wstrb), 32'(r.s));
                    end
                end
            end else if (!valid) vcnt = 0;
        end
    end

    initial begin : txmon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                repeat (bd / 2) @(negedge clk);
                chk("tx_startbit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (bd) @(negedge clk);
                    b[i] = txd;
                end
                repeat (bd) @(negedge clk);
                chk("tx_stopbit", 32'(txd), 32'd1);
                chk("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
                if (exp_tx.size() > 0) chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wstrb", 32'(wstrb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 0;
        repeat (5) @(negedge clk);
        write_cmd(32'h0000_1000, 32'hDEAD_BEEF);
        wait_done("t1_done");
        chk("t1_addr_hold", addr, 32'h0000_1000);
        chk("t1_wdata_hold", wdata, 32'hDEAD_BEEF);
        read_cmd(32'h0000_0004, 32'h1234_5678);
        wait_done("t2_done");
        chk("t2_wdata_hold", wdata, 32'hDEAD_BEEF);
        exp_tx.push_back(8'h15);
        send_byte(8'h41);
        wait_done("t3_done");
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk("t3_glitch_busy", 32'(busy), 32'd0);
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h10);
        chk("t4_busy_pending", 32'(busy), 32'd1);
        repeat (TO + 1) @(negedge clk);
        chk("t4_timeout_busy", 32'(busy), 32'd0);
        read_cmd(32'h0000_0004, 32'h1234_5678);
        wait_done("t4_done");
        send_byte(8'h57, 1'b0);
        repeat (100) @(negedge clk);
        chk("t5_frame_busy", 32'(busy), 32'd0);
        write_cmd(32'h0000_0020, 32'h0BAD_F00D);
        wait_done("t5_done");
        reset_in_req("t6_bd8");
        bd = 16'd4;
        reset_in_req("t6_bd4");
        write_cmd(32'hA5A5_0001, 32'hCAFE_F00D);
        wait_done("t6_wr_done");
        read_cmd(32'h8000_0010, 32'h8765_4321);
        wait_done("t6_rd_done");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
